// File: rtl/div_unit_if.sv
// Request/result bundle between the execute stage and the iterative divider.
// Latency: none, wires only.
// Backpressure: the requester holds off new starts while div_busy is high.
interface div_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  div_start;
    logic                  div_signed;
    logic [DATA_WIDTH-1:0] div_a;
    logic [DATA_WIDTH-1:0] div_b;
    logic                  div_cancel;
    logic                  div_busy;
    logic                  div_done;
    logic [DATA_WIDTH-1:0] div_q;
    logic [DATA_WIDTH-1:0] div_r;
    logic                  div_zero;

    // Pipeline side: issues requests, consumes results.
    modport master (
        output div_start, div_signed, div_a, div_b, div_cancel,
        input  div_busy, div_done, div_q, div_r, div_zero
    );

    // Divider side: consumes requests, produces results.
    modport slave (
        input  div_start, div_signed, div_a, div_b, div_cancel,
        output div_busy, div_done, div_q, div_r, div_zero
    );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU: quotient on div_q (LO), remainder on div_r (HI).
// Latency: 34 edges start-to-done (2 for a zero divisor), independent of operand values.
// Backpressure: div_busy high while working; starts during busy are ignored, cancel aborts silently.
module div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic       clk,
    input  logic       resetn,
    div_unit_if.slave  bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;

    // Iteration datapath: dividend shifts out MSB first into the partial remainder.
    logic [W-1:0]   dvd;
    logic [W-1:0]   dsr;
    logic [W-1:0]   quo;
    logic [W:0]     rem;
    logic [CW-1:0]  cnt;
    logic           q_neg;
    logic           r_neg;
    logic           zero_flag;

    // Control strobes decoded from the state.
    logic           accept;
    logic           step;
    logic           commit;

    // Operand conditioning and one restoring step.
    logic           a_neg;
    logic           b_neg;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;
    logic           b_is_zero;
    logic [W:0]     rem_sh;
    logic [W:0]     rem_sub;
    logic           rem_ge;

    // The partial remainder never exceeds the divisor, so its top bit is never shifted onward.
    logic           rem_top_unused;
    assign rem_top_unused = rem[W];

    // Strip signs for DIV so the iteration works on magnitudes; 2^31 still fits in W bits.
    always_comb begin
        a_neg     = bus.div_signed & bus.div_a[W-1];
        b_neg     = bus.div_signed & bus.div_b[W-1];
        a_mag     = a_neg ? -bus.div_a : bus.div_a;
        b_mag     = b_neg ? -bus.div_b : bus.div_b;
        b_is_zero = (bus.div_b == '0);
    end

    // One restoring step: shift in the next dividend bit, subtract the divisor if it fits.
    always_comb begin
        rem_sh  = {rem[W-1:0], dvd[W-1]};
        rem_ge  = (rem_sh >= {1'b0, dsr});
        rem_sub = rem_sh - {1'b0, dsr};
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; cancel beats a same-cycle start and aborts CALC/FIX.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.div_start && !bus.div_cancel) begin
                    state_nxt = b_is_zero ? FIX : CALC;
                end
            end
            CALC: begin
                if (bus.div_cancel) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output/strobe decode: busy is purely combinational from the state.
    always_comb begin
        bus.div_busy = (state != IDLE);
        accept       = (state == IDLE) && bus.div_start && !bus.div_cancel;
        step         = (state == CALC) && !bus.div_cancel;
        commit       = (state == FIX)  && !bus.div_cancel;
    end

    // Operand latch on accept, then one quotient bit per CALC cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dvd       <= '0;
            dsr       <= '0;
            quo       <= '0;
            rem       <= '0;
            cnt       <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            zero_flag <= 1'b0;
        end else if (accept) begin
            // A zero divisor skips CALC; keep the raw dividend for the remainder.
            dvd       <= b_is_zero ? bus.div_a : a_mag;
            dsr       <= b_mag;
            quo       <= '0;
            rem       <= '0;
            cnt       <= CW'(W - 1);
            q_neg     <= a_neg ^ b_neg;
            r_neg     <= a_neg;
            zero_flag <= b_is_zero;
        end else if (step) begin
            dvd <= {dvd[W-2:0], 1'b0};
            rem <= rem_ge ? rem_sub : rem_sh;
            quo <= {quo[W-2:0], rem_ge};
            if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // Result registers: written only in an uncancelled FIX, held otherwise.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.div_done <= 1'b0;
            bus.div_q    <= '0;
            bus.div_r    <= '0;
            bus.div_zero <= 1'b0;
        end else begin
            bus.div_done <= commit;
            if (commit) begin
                if (zero_flag) begin
                    bus.div_q    <= '1;
                    bus.div_r    <= dvd;
                    bus.div_zero <= 1'b1;
                end else begin
                    bus.div_q    <= q_neg ? -quo : quo;
                    bus.div_r    <= r_neg ? -rem[W-1:0] : rem[W-1:0];
                    bus.div_zero <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: model results queued at start, compared at div_done.
// Latency: checks 34-edge (2 for zero divisor) start-to-done and busy duration.
// Backpressure: exercises ignored starts, cancel, cancel+start, back-to-back and async reset.
module tb_div_unit;
    logic clk = 1'b0;
    logic resetn = 1'b0;

    always #5 clk = ~clk;

    div_unit_if #(.DATA_WIDTH(32)) bus_if ();

    div_unit #(.DATA_WIDTH(32)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if)
    );

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_exp;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference divide in 64-bit arithmetic: truncates toward zero, remainder follows dividend.
    function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
            e.z = 1'b1;
        end else begin
            sa  = s ? longint'($signed(a)) : longint'({32'd0, a});
            sb  = s ? longint'($signed(b)) : longint'({32'd0, b});
            e.q = 32'(sa / sb);
            e.r = 32'(sa % sb);
            e.z = 1'b0;
        end
        return e;
    endfunction

    // Result monitor: every completion must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (resetn && bus_if.div_done) begin
            check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("res_q", bus_if.div_q, e.q);
                check("res_r", bus_if.div_r, e.r);
                check("res_zero", 32'(bus_if.div_zero), 32'(e.z));
                last_exp = e;
            end
        end
    end

    // Issue one start pulse at a negedge; returns one negedge after the sampling edge.
    task automatic drive(input logic s, input logic [31:0] a, input logic [31:0] b, input bit expect_res);
        bus_if.div_signed = s;
        bus_if.div_a      = a;
        bus_if.div_b      = b;
        bus_if.div_start  = 1'b1;
        if (expect_res) sb_q.push_back(model(s, a, b));
        @(negedge clk);
        bus_if.div_start  = 1'b0;
    endtask

    // Count edges since the start sample until div_done, bounded.
    task automatic wait_done(input string tag, input int lat0, input int exp_lat);
        int lat    = lat0;
        int busy_n = 0;
        while (!bus_if.div_done && lat < 200) begin
            if (bus_if.div_busy) busy_n++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat - lat0));
        check({tag, "_busy_at_done"}, 32'(bus_if.div_busy), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b);
        int exp_lat;
        exp_lat = (b == 32'd0) ? 2 : 34;
        drive(s, a, b, 1'b1);
        wait_done(tag, 1, exp_lat);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(bus_if.div_done), 32'd0);
    endtask

    task automatic count_done(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus_if.div_done) seen++;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        logic        s;
        logic [31:0] a;
        logic [31:0] b;

        bus_if.div_start  = 1'b0;
        bus_if.div_signed = 1'b0;
        bus_if.div_a      = '0;
        bus_if.div_b      = '0;
        bus_if.div_cancel = 1'b0;
        last_exp.q = '0;
        last_exp.r = '0;
        last_exp.z = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus_if.div_busy), 32'd0);
        check("rst_done", 32'(bus_if.div_done), 32'd0);
        check("rst_q", bus_if.div_q, 32'd0);
        check("rst_r", bus_if.div_r, 32'd0);
        check("rst_zero", 32'(bus_if.div_zero), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        run_op("u100_7", 1'b0, 32'd100, 32'd7);
        run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_op("u_fff9_2", 1'b0, 32'hFFFF_FFF9, 32'd2);
        run_op("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
        run_op("div0", 1'b0, 32'h0000_1234, 32'd0);
        run_op("u9_3", 1'b0, 32'd9, 32'd3);
        run_op("s_div0", 1'b1, 32'h8000_0000, 32'd0);

        // Start pulsed while busy must not disturb the 50/5 operation.
        drive(1'b0, 32'd50, 32'd5, 1'b1);
        repeat (8) @(negedge clk);
        bus_if.div_a     = 32'd7;
        bus_if.div_b     = 32'd0;
        bus_if.div_start = 1'b1;
        @(negedge clk);
        bus_if.div_start = 1'b0;
        wait_done("ign_start", 10, 34);

        // Back-to-back: new start accepted in the done cycle.
        run_op("pre_b2b", 1'b0, 32'd1000, 32'd10);
        drive(1'b0, 32'd1000, 32'd10, 1'b1);
        wait_done("b2b_first", 1, 34);
        drive(1'b1, 32'(-100), 32'd7, 1'b1);
        wait_done("b2b_second", 1, 34);
        @(negedge clk);

        // Cancel mid-CALC: busy drops, no completion, results retained.
        drive(1'b0, 32'd12345, 32'd67, 1'b0);
        repeat (13) @(negedge clk);
        bus_if.div_cancel = 1'b1;
        @(negedge clk);
        bus_if.div_cancel = 1'b0;
        check("cancel_busy", 32'(bus_if.div_busy), 32'd0);
        count_done("cancel_no_done", 40);
        check("cancel_keep_q", bus_if.div_q, last_exp.q);
        check("cancel_keep_r", bus_if.div_r, last_exp.r);
        check("cancel_keep_zero", 32'(bus_if.div_zero), 32'(last_exp.z));

        // Cancel and start together while idle: start is dropped.
        bus_if.div_cancel = 1'b1;
        drive(1'b0, 32'd77, 32'd7, 1'b0);
        bus_if.div_cancel = 1'b0;
        check("cancel_start_busy", 32'(bus_if.div_busy), 32'd0);
        count_done("cancel_start_no_done", 40);

        // Mixed random operands, with zero and small divisors mixed in.
        for (int i = 0; i < 10; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 5));
            else                           b = $urandom >> $urandom_range(0, 31);
            run_op("rand", s, a, b);
        end

        // Asynchronous reset mid-CALC clears everything without a clock edge.
        drive(1'b0, 32'd999, 32'd3, 1'b0);
        repeat (5) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("arst_busy", 32'(bus_if.div_busy), 32'd0);
        check("arst_done", 32'(bus_if.div_done), 32'd0);
        check("arst_q", bus_if.div_q, 32'd0);
        check("arst_r", bus_if.div_r, 32'd0);
        check("arst_zero", 32'(bus_if.div_zero), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        run_op("post_rst", 1'b1, 32'd77, 32'hFFFF_FFF9);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
